// File: rtl/clk_rst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_rst_ctrl                                                     |
// | Brief    : POR/soft-reset sequencer, debounced step key and core clock     |
// |            enable generator (STOP/STEP/DIV/RUN) in the clk50 domain.       |
// |            Optional macro CLK_RST_CTRL_STEP_CNT_EN adds the step counter.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clk_rst_ctrl #(
   parameter int POR_CYCLES      = 33554432,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DIV_W           = 8
) (
   input  logic             clk50,
   input  logic             rst,
   input  logic             rst_req,
   input  logic             step_key_n,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div_sel,
   output logic             sys_rst,
   output logic             core_ce,
   output logic             key_db,
   output logic [15:0]      step_count
);

   localparam int c_POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
   localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_POR_W-1:0] c_POR_LAST = c_POR_W'(POR_CYCLES - 1);
   localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] c_MODE_STOP = 2'd0;
   localparam logic [1:0] c_MODE_STEP = 2'd1;
   localparam logic [1:0] c_MODE_DIV  = 2'd2;
   localparam logic [1:0] c_MODE_RUN  = 2'd3;

   typedef enum logic [0:0] {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [c_POR_W-1:0] r_por_cnt;
   logic [c_POR_W-1:0] w_por_cnt_next;
   logic [DIV_W-1:0]   r_div_cnt;
   logic [DIV_W-1:0]   w_div_cnt_next;
   logic               r_core_ce;
   logic               w_core_ce_next;
   logic               r_sync1;
   logic               r_sync2;
   logic               w_key_sample;
   logic [c_DB_W-1:0]  r_db_cnt;
   logic               r_key_db;
   logic               r_key_db_d;
   logic               w_key_rise;

   assign w_key_sample = ~r_sync2;
   assign w_key_rise   = r_key_db & ~r_key_db_d;

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_state   <= ST_HOLD;
         r_por_cnt <= '0;
         r_div_cnt <= '0;
         r_core_ce <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_por_cnt <= w_por_cnt_next;
         r_div_cnt <= w_div_cnt_next;
         r_core_ce <= w_core_ce_next;
      end
   end

   // Enable is suppressed on the HOLD->RUN edge and on a soft-reset edge alike.
   always_comb begin
      w_state_next   = r_state;
      w_por_cnt_next = '0;
      w_div_cnt_next = '0;
      w_core_ce_next = 1'b0;
      if (rst_req) begin
         w_state_next = ST_HOLD;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_por_cnt == c_POR_LAST) begin
                  w_state_next = ST_RUN;
               end else begin
                  w_por_cnt_next = r_por_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               case (mode)
                  c_MODE_STOP: w_core_ce_next = 1'b0;
                  c_MODE_STEP: w_core_ce_next = w_key_rise;
                  c_MODE_DIV: begin
                     if (r_div_cnt >= div_sel) begin
                        w_core_ce_next = 1'b1;
                     end else begin
                        w_div_cnt_next = r_div_cnt + 1'b1;
                     end
                  end
                  c_MODE_RUN:  w_core_ce_next = 1'b1;
               endcase
            end
         endcase
      end
   end

   // Debounce keeps running through HOLD; only the hard reset clears it.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_db_cnt   <= '0;
         r_key_db   <= 1'b0;
         r_key_db_d <= 1'b0;
      end else begin
         r_sync1    <= step_key_n;
         r_sync2    <= r_sync1;
         r_key_db_d <= r_key_db;
         if (w_key_sample == r_key_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == c_DB_LAST) begin
            r_key_db <= w_key_sample;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   assign sys_rst = (r_state == ST_HOLD);
   assign core_ce = r_core_ce;
   assign key_db  = r_key_db;

`ifdef CLK_RST_CTRL_STEP_CNT_EN
   logic [15:0] r_step_cnt;

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_step_cnt <= '0;
      end else if (rst_req || (r_state == ST_HOLD)) begin
         r_step_cnt <= '0;
      end else if (r_core_ce) begin
         r_step_cnt <= r_step_cnt + 16'd1;
      end
   end

   assign step_count = r_step_cnt;
`else
   assign step_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_clk_rst_ctrl                                                  |
// | Brief    : Self-checking bench for clk_rst_ctrl against a behavioural model.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_clk_rst_ctrl;

   localparam int c_POR = 16;
   localparam int c_DB  = 4;
   localparam int c_DW  = 4;
`ifdef CLK_RST_CTRL_STEP_CNT_EN
   localparam bit c_CNT_EN = 1'b1;
`else
   localparam bit c_CNT_EN = 1'b0;
`endif

   logic            clk50 = 1'b0;
   logic            rst;
   logic            rst_req;
   logic            step_key_n;
   logic [1:0]      mode;
   logic [c_DW-1:0] div_sel;
   logic            sys_rst;
   logic            core_ce;
   logic            key_db;
   logic [15:0]     step_count;

   int n_checks = 0;
   int n_errors = 0;

   clk_rst_ctrl #(
      .POR_CYCLES      (c_POR),
      .DEBOUNCE_CYCLES (c_DB),
      .DIV_W           (c_DW)
   ) u_dut (
      .clk50      (clk50),
      .rst        (rst),
      .rst_req    (rst_req),
      .step_key_n (step_key_n),
      .mode       (mode),
      .div_sel    (div_sel),
      .sys_rst    (sys_rst),
      .core_ce    (core_ce),
      .key_db     (key_db),
      .step_count (step_count)
   );

   always #5 clk50 = ~clk50;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk50);
      #1;
   endtask

   // Behavioural model: reset hold as a countdown of remaining cycles, the key
   // as a window of recent synchronised samples, DIV as elapsed cycles.
   int          m_hold;
   bit          m_ce;
   bit          m_key;
   bit          m_key_prev;
   bit          m_s1;
   bit          m_s2;
   int          m_elapsed;
   int unsigned m_steps;
   bit          m_hist[$];
   bit          t_blocked;
   bit          t_sample;
   bit          t_ce;
   bit          t_key;
   bit          t_same;

   always @(posedge clk50 or posedge rst) begin
      if (rst) begin
         m_hold     = c_POR;
         m_ce       = 1'b0;
         m_key      = 1'b0;
         m_key_prev = 1'b0;
         m_s1       = 1'b1;
         m_s2       = 1'b1;
         m_elapsed  = 0;
         m_steps    = 0;
         m_hist.delete();
      end else begin
         t_blocked = (m_hold > 0) || rst_req;
         t_sample  = !m_s2;
         if (t_blocked)
            m_steps = 0;
         else if (m_ce)
            m_steps = (m_steps + 1) % 65536;
         t_ce = 1'b0;
         if (t_blocked || mode != 2'd2) begin
            m_elapsed = 0;
         end else if (m_elapsed >= int'(div_sel)) begin
            t_ce      = 1'b1;
            m_elapsed = 0;
         end else begin
            m_elapsed = m_elapsed + 1;
         end
         if (!t_blocked) begin
            if (mode == 2'd3) t_ce = 1'b1;
            if (mode == 2'd1) t_ce = m_key && !m_key_prev;
         end
         m_ce = t_ce;
         if (rst_req) m_hold = c_POR;
         else if (m_hold > 0) m_hold = m_hold - 1;
         m_hist.push_back(t_sample);
         if (m_hist.size() > c_DB) void'(m_hist.pop_front());
         t_key = m_key;
         if (m_hist.size() == c_DB) begin
            t_same = 1'b1;
            foreach (m_hist[k]) if (m_hist[k] != m_hist[0]) t_same = 1'b0;
            if (t_same) t_key = m_hist[0];
         end
         m_key_prev = m_key;
         m_key      = t_key;
         m_s2       = m_s1;
         m_s1       = step_key_n;
      end
   end

   always @(negedge clk50) begin
      chk("sys_rst", int'(sys_rst), int'(m_hold > 0));
      chk("core_ce", int'(core_ce), int'(m_ce));
      chk("key_db", int'(key_db), int'(m_key));
      chk("step_count", int'(step_count), c_CNT_EN ? int'(m_steps) : 0);
   end

   int          cnt;
   int          pulses;
   int          lat;
   logic [6:0]  pat;
   logic [9:0]  bounce;

   initial begin
      rst        = 1'b1;
      rst_req    = 1'b0;
      step_key_n = 1'b1;
      mode       = 2'd3;
      div_sel    = '0;
      repeat (3) tick();
      chk("rst_sys_rst", int'(sys_rst), 1);
      chk("rst_core_ce", int'(core_ce), 0);
      chk("rst_key_db", int'(key_db), 0);
      chk("rst_step_count", int'(step_count), 0);

      // Power-on hold length, then RUN.
      rst = 1'b0;
      cnt = 0;
      while (sys_rst && cnt < 40) begin
         cnt++;
         tick();
      end
      chk("por_hold_len", cnt, 16);
      chk("ce_on_release", int'(core_ce), 0);
      tick();
      chk("ce_run", int'(core_ce), 1);
      repeat (4) tick();
      chk("run_step_count", int'(step_count), c_CNT_EN ? 4 : 0);

      // Soft reset at step_count 0x40.
      for (int k = 0; k < 80 && step_count != 16'h0040; k++) tick();
      chk("step_count_40", int'(step_count), c_CNT_EN ? 64 : 0);
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      chk("req_sys_rst", int'(sys_rst), 1);
      chk("req_core_ce", int'(core_ce), 0);
      chk("req_step_count", int'(step_count), 0);
      cnt = 0;
      while (sys_rst && cnt < 40) begin
         cnt++;
         tick();
      end
      chk("req_hold_len", cnt, 16);

      // DIV by 4.
      mode    = 2'd2;
      div_sel = 4'd3;
      pulses  = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         pulses += int'(core_ce);
      end
      chk("div4_pulses", pulses, 5);
      tick();
      chk("div4_step_count", int'(step_count), c_CNT_EN ? 5 : 0);

      // Shrinking div_sel below the running count.
      mode = 2'd0;
      tick();
      mode    = 2'd2;
      div_sel = 4'd12;
      repeat (9) tick();
      div_sel = 4'd2;
      pat     = '0;
      for (int k = 0; k < 7; k++) begin
         tick();
         pat = {pat[5:0], core_ce};
      end
      chk("div_shrink_pattern", int'(pat), int'(7'b1001001));

      // STEP with a bouncy press.
      mode   = 2'd1;
      bounce = 10'b0000001010;
      pulses = 0;
      lat    = -1;
      for (int k = 0; k < 24; k++) begin
         step_key_n = (k < 10) ? bounce[k] : 1'b1;
         tick();
         pulses += int'(core_ce);
         if (key_db && lat < 0) lat = k - 3;
      end
      chk("step_pulses", pulses, 1);
      chk("step_key_latency_ok", int'(lat >= 1 && lat <= 8), 1);

      // Asynchronous reset mid-DIV and mid-debounce.
      mode       = 2'd2;
      div_sel    = 4'd2;
      step_key_n = 1'b0;
      repeat (10) tick();
      step_key_n = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("async_sys_rst", int'(sys_rst), 1);
      chk("async_core_ce", int'(core_ce), 0);
      chk("async_key_db", int'(key_db), 0);
      chk("async_step_count", int'(step_count), 0);
      tick();
      rst = 1'b0;

      // Randomised traffic checked cycle-by-cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 199));
         rst_req = 1'b0;
         if (r < 6) mode = 2'($urandom_range(0, 3));
         else if (r < 12) div_sel = c_DW'($urandom_range(0, 15));
         else if (r == 12) rst_req = 1'b1;
         else if (r == 13) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         if ($urandom_range(0, 5) == 0) step_key_n = ~step_key_n;
         tick();
      end
      rst_req = 1'b0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
